// File: rtl/rest_dispenser.sv
// rest_dispenser
//   Change-coin hopper controller for a vending machine. A change request
//   latches the number of 1-leu coins to pay out. The hopper motor runs until
//   that many coins have been seen on the exit sensor, or until the hopper
//   runs empty, which is a fault. A fault is cleared by clr. refill reloads
//   the stock count while idle.
//
//   Optional feature: define REST_DISPENSER_TIMEOUT_EN to compile in a jam
//   timer. It faults the payout when no coin has appeared for TIMEOUT_CYC
//   cycles while the motor runs.
//
// Parameters
//   HOPPER_INIT  stock count loaded on reset and on refill (1..255)
//   TIMEOUT_CYC  jam timer limit in cycles (1..65535), used only with the macro
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   rest        one-cycle change request
//   amount[3:0] coins to pay, sampled only while rest=1
//   coin_sense  raw hopper exit sensor, asynchronous, high while a coin passes
//   refill      one-cycle pulse that reloads the stock count (idle only)
//   clr         one-cycle pulse that clears a fault
//   motor       hopper motor drive (high in RUN)
//   busy        high in RUN
//   done        one-cycle pulse when a payout completes
//   fault       high in FAULT
//   paid[3:0]   coins paid in the current or most recent payout
//   stock[7:0]  coins remaining in the hopper
//   req_drop    one-cycle pulse when a request arrives outside IDLE
module rest_dispenser #(
  parameter int HOPPER_INIT = 50,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rest,
  input  logic [3:0] amount,
  input  logic       coin_sense,
  input  logic       refill,
  input  logic       clr,
  output logic       motor,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] paid,
  output logic [7:0] stock,
  output logic       req_drop
);

  localparam logic [7:0] STOCK_INIT = 8'(HOPPER_INIT);

  // Parameter range checks. These are evaluated at elaboration time only.
  if (HOPPER_INIT < 1 || HOPPER_INIT > 255) begin : g_bad_hopper_init
    $error("rest_dispenser: HOPPER_INIT out of range 1..255");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout_cyc
    $error("rest_dispenser: TIMEOUT_CYC out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  target, target_next;
  logic [3:0]  paid_next;
  logic [7:0]  stock_next;
  logic        done_next;
  logic        drop_next;

  logic        sync1, sync2, sync3;
  logic        coin_event;

  // The sensor is asynchronous. sync1/sync2 resynchronise it, and sync3 is
  // the previous synchronised value. A coin counts once, on its rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= coin_sense;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign coin_event = sync2 & ~sync3;

`ifdef REST_DISPENSER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

  logic [15:0] tmr, tmr_next;

  // Jam timer: the number of cycles since RUN entry or since the last coin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr <= 16'd0;
    end else begin
      tmr <= tmr_next;
    end
  end
`endif

  // Next-state and datapath decisions. Each coin is applied in the cycle its
  // event is seen. The exit decision uses the post-coin values, so done and
  // motor=0 appear together with the final paid count.
  always_comb begin
    state_next  = state;
    target_next = target;
    paid_next   = paid;
    stock_next  = stock;
    done_next   = 1'b0;
    drop_next   = 1'b0;
`ifdef REST_DISPENSER_TIMEOUT_EN
    tmr_next    = tmr;
`endif
    case (state)
      IDLE: begin
        // A request has priority over a simultaneous refill.
        if (rest) begin
          paid_next = 4'd0;
          if (amount == 4'd0) begin
            done_next = 1'b1;
          end else if (stock == 8'd0) begin
            state_next = FAULT;
          end else begin
            target_next = amount;
            state_next  = RUN;
`ifdef REST_DISPENSER_TIMEOUT_EN
            tmr_next    = 16'd0;
`endif
          end
        end else if (refill) begin
          stock_next = STOCK_INIT;
        end
      end
      RUN: begin
        drop_next = rest;
        if (coin_event && stock != 8'd0) begin
          paid_next  = paid + 4'd1;
          stock_next = stock - 8'd1;
`ifdef REST_DISPENSER_TIMEOUT_EN
          tmr_next   = 16'd0;
`endif
          // A payout that empties the hopper on its last coin still completes.
          if (paid + 4'd1 == target) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (stock == 8'd1) begin
            state_next = FAULT;
          end
        end
`ifdef REST_DISPENSER_TIMEOUT_EN
        else if (tmr == TIMEOUT_LIM) begin
          state_next = FAULT;
        end else begin
          tmr_next = tmr + 16'd1;
        end
`endif
      end
      FAULT: begin
        drop_next = rest;
        if (clr) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. motor, busy and fault are decoded from the
  // next state, so they stay aligned with the state register. An
  // asynchronous reset clears them at once, including the motor during RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      target   <= 4'd0;
      paid     <= 4'd0;
      stock    <= STOCK_INIT;
      done     <= 1'b0;
      req_drop <= 1'b0;
      motor    <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_next;
      target   <= target_next;
      paid     <= paid_next;
      stock    <= stock_next;
      done     <= done_next;
      req_drop <= drop_next;
      motor    <= (state_next == RUN);
      busy     <= (state_next == RUN);
      fault    <= (state_next == FAULT);
    end
  end

endmodule
